seg7_scan_mux: RTL and testbench
================================

// Module: seg7_scan_mux
// PURPOSE
//  Time-multiplexes an NDIG-digit hex value onto one shared 7-segment bus.
//  Drives the 4-bit digit code into the downstream 7-segment decoder input and
//  the active-low common-anode enables. Dead time between digits prevents ghosting.
//  Value updates are double-buffered and take effect only at frame boundaries,
//  so the display never tears.
// PARAMETERS
//  NDIG   4      number of digits (>=2)
//  DWELL  50000  clocks per digit slot (>=BLANK+1)
//  BLANK  16     dead clocks at start of each slot, all anodes off (>=1)
// PORTS
//  clk         in   1        system clock, rising edge
//  rst_n       in   1        asynchronous, active-low reset
//  en          in   1        scan enable; 0 = display dark
//  load        in   1        capture value into pending buffer this cycle
//  value       in   4*NDIG   digits, nibble k = digit k (digit 0 = rightmost)
//  lz_en       in   1        leading-zero suppression enable
//  digit_code  out  4        nibble for decoder input (registered)
//  an_n        out  NDIG     anode enables, active low (registered)
//  digit_idx   out  $clog2(NDIG)  slot currently scanned
//  frame_done  out  1        1-cycle pulse when slot NDIG-1 ends
// BEHAVIOUR
//  Reset (async, rst_n=0): an_n=all 1, digit_code=0, digit_idx=0, frame_done=0,
//   pending=active=0, pend_vld=0, tick=0, state=IDLE.
//  States: IDLE, BLANK, DRIVE. tick counts 0..DWELL-1 within a slot.
//   IDLE : en=1 -> BLANK, tick=0, idx=0. an_n all 1.
//   BLANK: tick==BLANK-1 -> DRIVE. an_n all 1.
//   DRIVE: tick==DWELL-1 -> BLANK, tick=0, idx=idx+1 mod NDIG.
//   Any state: en=0 -> IDLE next cycle; tick and idx cleared; buffers kept.
//  Outputs are registered from the same-cycle state/tick/idx, so each output
//   lags its cause by exactly 1 clk.
//   During DRIVE: an_n[idx]=0, all other bits 1; digit_code=active[4*idx+:4].
//   During BLANK: digit_code updates to the new idx. Code settles before the anode turns on.
//  Leading-zero suppression: lz_en=1, idx!=0, and active digits idx..NDIG-1 all zero
//   -> an_n stays all 1 for that slot (timing unchanged). Digit 0 is always shown.
//  Buffering: load=1 -> pending<=value, pend_vld<=1. A later load overwrites it; last wins.
//   Frame boundary = DRIVE cycle with tick==DWELL-1 and idx==NDIG-1.
//   At the boundary: if load=1, active<=value; else if pend_vld, active<=pending.
//   pend_vld<=0 in both cases.
//   First load after IDLE->BLANK with active==0 is still deferred to a boundary.
//  frame_done asserts 1 clk after the boundary cycle, for exactly one cycle.
//   It never asserts in IDLE.
//  Counters wrap without overflow. tick width = $clog2(DWELL).
//  Reset mid-scan: all outputs return to reset values immediately (async).
// STRUCTURE
//  seg7_pkg: state enum (IDLE/BLANK/DRIVE), localparam helpers for counter widths,
//   default NDIG.
//  Sub-module seg7_lz_mask: combinational, value in -> NDIG-bit suppress mask.
//   Reused by other display blocks.
//  Top level wires digit_code to the decoder input and an_n to the pads.
//   This block does not instantiate the decoder.
// TESTING (bench uses NDIG=4, DWELL=8, BLANK=2)
//  Reset: hold rst_n=0 with en=1 -> an_n=4'b1111, digit_code=0, frame_done=0.
//   Release rst_n -> first an_n=4'b1110 appears 3 clks after leaving IDLE.
//  Scan order: load value=16'h1234, wait 2 frames -> per slot, digit_code=4,3,2,1.
//   an_n low for 6 of 8 clks per slot, in the sequence 1110,1101,1011,0111.
//   frame_done pulses every 32 clks.
//  No tear: load 16'hABCD mid-frame, then 16'h5678 two cycles later.
//   -> current frame still shows the old value; next frame shows 5678. ABCD is never displayed.
//  Leading zeros: value=16'h0070, lz_en=1 -> slots 3 and 2 keep an_n=1111.
//   Slots 1 and 0 drive 7 and 0. With lz_en=0, all 4 slots drive.
//  Enable drop: en=0 during DRIVE of slot 2 -> next cycle an_n=1111, digit_idx=0, no frame_done.
//   en=1 again -> restarts at slot 0 with a BLANK phase.
//  Boundary collision: load=1 on the exact boundary cycle with value=16'h9999
//   -> the next frame shows 9999, and pend_vld is clear afterwards.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared types and width helpers for the 7-segment scan blocks.
//   state_t      : scan FSM state (idle / blank dead-time / drive)
//   NDIG_DEFAULT : default number of digits
//   cnt_w()      : bit width needed for a counter of n states (minimum 1)
package seg7_pkg;

  localparam int NDIG_DEFAULT = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BLANK = 2'd1,
    ST_DRIVE = 2'd2
  } state_t;

  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/seg7_lz_mask.sv
// Leading-zero mask for a packed multi-digit hex value.
//   value    in  4*NDIG  nibble k = digit k (digit 0 = rightmost)
//   suppress out NDIG    bit k set when digits k..NDIG-1 are all zero
// Bit 0 therefore means "whole value is zero"; callers that must keep the
// units digit visible ignore bit 0.
module seg7_lz_mask import seg7_pkg::*; #(
  parameter int NDIG = NDIG_DEFAULT
) (
  input  logic [4*NDIG-1:0] value,
  output logic [NDIG-1:0]   suppress
);

  // upper_zero[k]: every nibble from k up to the top is zero.
  logic [NDIG:0] upper_zero;

  assign upper_zero[NDIG] = 1'b1;

  for (genvar gi = 0; gi < NDIG; gi++) begin : g_chain
    assign upper_zero[gi] = upper_zero[gi+1] && (value[4*gi +: 4] == 4'h0);
  end

  assign suppress = upper_zero[NDIG-1:0];

endmodule

// File: rtl/seg7_scan_mux.sv
// Time-multiplexes an NDIG-digit hex value onto one shared 7-segment bus.
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   en         in   scan enable; 0 = display dark
//   load       in   capture value into the pending buffer this cycle
//   value      in   4*NDIG packed digits, nibble k = digit k
//   lz_en      in   leading-zero suppression enable
//   digit_code out  registered nibble for the downstream segment decoder
//   an_n       out  registered active-low common-anode enables
//   digit_idx  out  slot currently being scanned
//   frame_done out  1-cycle pulse after the last slot of a frame ends
// Each slot is DWELL clocks: BLANK dead clocks with all anodes off (the code
// settles here), then the anode of the slot is driven. New values are staged
// in a pending buffer and copied to the active buffer only at frame ends.
module seg7_scan_mux import seg7_pkg::*; #(
  parameter int NDIG  = NDIG_DEFAULT,
  parameter int DWELL = 50000,
  parameter int BLANK = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic                     load,
  input  logic [4*NDIG-1:0]        value,
  input  logic                     lz_en,
  output logic [3:0]               digit_code,
  output logic [NDIG-1:0]          an_n,
  output logic [$clog2(NDIG)-1:0]  digit_idx,
  output logic                     frame_done
);

  localparam int TW = cnt_w(DWELL);
  localparam int IW = cnt_w(NDIG);
  localparam logic [TW-1:0] TICK_LAST  = TW'(DWELL - 1);
  localparam logic [TW-1:0] BLANK_LAST = TW'(BLANK - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NDIG - 1);

  state_t            state_reg;
  logic [TW-1:0]     tick_reg;
  logic [IW-1:0]     idx_reg;
  logic [4*NDIG-1:0] pending_reg;
  logic [4*NDIG-1:0] active_reg;
  logic              pend_vld_reg;
  logic [3:0]        digit_code_reg;
  logic [NDIG-1:0]   an_n_reg;
  logic              frame_done_reg;

  logic [3:0]        nib [NDIG];
  logic [NDIG-1:0]   zero_mask;
  logic [NDIG-1:0]   an_n_next;
  logic [3:0]        digit_code_next;
  logic              slot_blank;
  logic              boundary;

  seg7_lz_mask #(.NDIG(NDIG)) u_lz_mask (
    .value    (active_reg),
    .suppress (zero_mask)
  );

  for (genvar gi = 0; gi < NDIG; gi++) begin : g_nib
    assign nib[gi] = active_reg[4*gi +: 4];
  end

  // Last DRIVE cycle of the last slot. Gated by en so a frame that is cut
  // short by en=0 neither swaps buffers nor reports completion.
  assign boundary = en && (state_reg == ST_DRIVE) && (tick_reg == TICK_LAST)
                    && (idx_reg == IDX_LAST);

  // Digit 0 is never suppressed, so the value 0 still shows a single "0".
  assign slot_blank = lz_en && (idx_reg != '0) && zero_mask[idx_reg];

  // en=0 darkens the anodes on the very next clock rather than one later.
  for (genvar gi = 0; gi < NDIG; gi++) begin : g_an
    assign an_n_next[gi] = !(en && (state_reg == ST_DRIVE)
                             && (idx_reg == IW'(gi)) && !slot_blank);
  end

  assign digit_code_next = (en && (state_reg != ST_IDLE)) ? nib[idx_reg] : 4'h0;

  // Scan FSM plus the registered outputs derived from it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= ST_IDLE;
      tick_reg       <= '0;
      idx_reg        <= '0;
      an_n_reg       <= '1;
      digit_code_reg <= 4'h0;
      frame_done_reg <= 1'b0;
    end else begin
      an_n_reg       <= an_n_next;
      digit_code_reg <= digit_code_next;
      frame_done_reg <= boundary;
      if (!en) begin
        state_reg <= ST_IDLE;
        tick_reg  <= '0;
        idx_reg   <= '0;
      end else begin
        case (state_reg)
          ST_IDLE: begin
            state_reg <= ST_BLANK;
            tick_reg  <= '0;
            idx_reg   <= '0;
          end
          ST_BLANK: begin
            tick_reg <= tick_reg + TW'(1);
            if (tick_reg == BLANK_LAST) state_reg <= ST_DRIVE;
          end
          ST_DRIVE: begin
            if (tick_reg == TICK_LAST) begin
              state_reg <= ST_BLANK;
              tick_reg  <= '0;
              idx_reg   <= (idx_reg == IDX_LAST) ? '0 : idx_reg + IW'(1);
            end else begin
              tick_reg <= tick_reg + TW'(1);
            end
          end
          default: begin
            state_reg <= ST_IDLE;
            tick_reg  <= '0;
            idx_reg   <= '0;
          end
        endcase
      end
    end
  end

  // Double buffer: a load on the boundary cycle itself goes straight to the
  // active buffer, otherwise the newest pending value is promoted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_reg  <= '0;
      active_reg   <= '0;
      pend_vld_reg <= 1'b0;
    end else begin
      if (load) pending_reg <= value;
      if (boundary) begin
        if (load)              active_reg <= value;
        else if (pend_vld_reg) active_reg <= pending_reg;
        pend_vld_reg <= 1'b0;
      end else if (load) begin
        pend_vld_reg <= 1'b1;
      end
    end
  end

  assign digit_code = digit_code_reg;
  assign an_n       = an_n_reg;
  assign digit_idx  = idx_reg;
  assign frame_done = frame_done_reg;

endmodule

// File: tb/tb_seg7_scan_mux.sv
// Directed testbench for seg7_scan_mux with NDIG=4, DWELL=8, BLANK=2.
// A frame is 32 clocks; outputs are sampled on the falling edge.
module tb_seg7_scan_mux;

  localparam int NDIG  = 4;
  localparam int DWELL = 8;
  localparam int BLANK = 2;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        en    = 1'b0;
  logic        load  = 1'b0;
  logic        lz_en = 1'b0;
  logic [15:0] value = 16'h0;
  logic [3:0]  digit_code;
  logic [3:0]  an_n;
  logic [1:0]  digit_idx;
  logic        frame_done;

  int checks   = 0;
  int failures = 0;

  logic [3:0] obs_an [32];
  logic [3:0] obs_dc [32];
  logic       obs_fd [32];

  always #5 clk = ~clk;

  seg7_scan_mux #(.NDIG(NDIG), .DWELL(DWELL), .BLANK(BLANK)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .load       (load),
    .value      (value),
    .lz_en      (lz_en),
    .digit_code (digit_code),
    .an_n       (an_n),
    .digit_idx  (digit_idx),
    .frame_done (frame_done)
  );

  // Expected anode pattern for slot s, clock t within the slot.
  function automatic logic [3:0] exp_an(input int s, input int t, input logic [3:0] show);
    logic [3:0] one;
    one = 4'b0001;
    if (t >= BLANK && show[s]) return ~(one << s);
    return 4'hF;
  endfunction

  // Advance to the falling edge at which frame_done is high (mid cycle 0 of a frame).
  task automatic wait_frame(input string tag);
    int n;
    n = 0;
    while (frame_done !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (frame_done !== 1'b1) begin
      failures++;
      $display("FAIL %s_sync frame_done=%b required=1 after %0d clks", tag, frame_done, n);
    end
  endtask

  // Record one full frame; optional one-cycle loads into frame cycle k+1.
  task automatic capture_frame(input int k1, input logic [15:0] v1,
                               input int k2, input logic [15:0] v2);
    for (int k = 0; k < 32; k++) begin
      @(negedge clk);
      obs_an[k] = an_n;
      obs_dc[k] = digit_code;
      obs_fd[k] = frame_done;
      load = 1'b0;
      if (k == k1) begin load = 1'b1; value = v1; end
      if (k == k2) begin load = 1'b1; value = v2; end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (an_n !== 4'hF || digit_code !== 4'h0 || frame_done !== 1'b0 || digit_idx !== 2'd0) begin
      failures++;
      $display("FAIL reset_hold an_n=%b code=%h fd=%b idx=%0d required 1111/0/0/0",
               an_n, digit_code, frame_done, digit_idx);
    end
    rst_n = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      checks++;
      if (an_n !== ((i == 4) ? 4'b1110 : 4'b1111) || digit_code !== 4'h0) begin
        failures++;
        $display("FAIL reset_release clk=%0d an_n=%b required=%b code=%h required=0",
                 i, an_n, (i == 4) ? 4'b1110 : 4'b1111, digit_code);
      end
    end
    $display("reset: hold and release sequence checked");
  endtask

  task automatic test_scan_order();
    logic [15:0] ev;
    wait_frame("scan");
    load = 1'b1; value = 16'h1234;
    capture_frame(-1, 16'h0, -1, 16'h0);
    ev = 16'h0000;
    for (int k = 0; k < 32; k++) begin
      checks++;
      if (obs_an[k] !== exp_an(k/8, k%8, 4'hF) || obs_dc[k] !== ev[4*(k/8) +: 4] || obs_fd[k] !== (k == 31)) begin
        failures++;
        $display("FAIL scan_deferred k=%0d an_n=%b req=%b code=%h req=%h fd=%b req=%b",
                 k, obs_an[k], exp_an(k/8, k%8, 4'hF), obs_dc[k], ev[4*(k/8) +: 4], obs_fd[k], k == 31);
      end
    end
    $display("scan: frame before first load takes effect checked");
    capture_frame(-1, 16'h0, -1, 16'h0);
    ev = 16'h1234;
    for (int k = 0; k < 32; k++) begin
      checks++;
      if (obs_an[k] !== exp_an(k/8, k%8, 4'hF) || obs_dc[k] !== ev[4*(k/8) +: 4] || obs_fd[k] !== (k == 31)) begin
        failures++;
        $display("FAIL scan_1234 k=%0d an_n=%b req=%b code=%h req=%h fd=%b req=%b",
                 k, obs_an[k], exp_an(k/8, k%8, 4'hF), obs_dc[k], ev[4*(k/8) +: 4], obs_fd[k], k == 31);
      end
    end
    $display("scan: frame showing 1234 checked");
  endtask

  task automatic test_no_tear();
    logic [15:0] ev;
    capture_frame(10, 16'hABCD, 12, 16'h5678);
    ev = 16'h1234;
    for (int k = 0; k < 32; k++) begin
      checks++;
      if (obs_an[k] !== exp_an(k/8, k%8, 4'hF) || obs_dc[k] !== ev[4*(k/8) +: 4] || obs_fd[k] !== (k == 31)) begin
        failures++;
        $display("FAIL tear_old k=%0d an_n=%b req=%b code=%h req=%h fd=%b req=%b",
                 k, obs_an[k], exp_an(k/8, k%8, 4'hF), obs_dc[k], ev[4*(k/8) +: 4], obs_fd[k], k == 31);
      end
    end
    capture_frame(-1, 16'h0, -1, 16'h0);
    ev = 16'h5678;
    for (int k = 0; k < 32; k++) begin
      checks++;
      if (obs_an[k] !== exp_an(k/8, k%8, 4'hF) || obs_dc[k] !== ev[4*(k/8) +: 4] || obs_fd[k] !== (k == 31)) begin
        failures++;
        $display("FAIL tear_new k=%0d an_n=%b req=%b code=%h req=%h fd=%b req=%b",
                 k, obs_an[k], exp_an(k/8, k%8, 4'hF), obs_dc[k], ev[4*(k/8) +: 4], obs_fd[k], k == 31);
      end
    end
    $display("no_tear: mid-frame loads deferred, last load 5678 shown");
  endtask

  task automatic test_enable_drop();
    repeat (19) @(negedge clk);
    checks++;
    if (an_n !== 4'b1011) begin
      failures++;
      $display("FAIL endrop_slot2 an_n=%b required=1011", an_n);
    end
    en = 1'b0;
    @(negedge clk);
    checks++;
    if (an_n !== 4'hF || digit_idx !== 2'd0 || frame_done !== 1'b0) begin
      failures++;
      $display("FAIL endrop_next an_n=%b idx=%0d fd=%b required 1111/0/0", an_n, digit_idx, frame_done);
    end
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      checks++;
      if (an_n !== 4'hF || frame_done !== 1'b0) begin
        failures++;
        $display("FAIL endrop_dark clk=%0d an_n=%b fd=%b required 1111/0", i, an_n, frame_done);
      end
    end
    en = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      checks++;
      if (an_n !== ((i == 4) ? 4'b1110 : 4'b1111) || digit_idx !== 2'd0 ||
          (i >= 3 && digit_code !== 4'h8)) begin
        failures++;
        $display("FAIL endrop_restart clk=%0d an_n=%b req=%b idx=%0d code=%h",
                 i, an_n, (i == 4) ? 4'b1110 : 4'b1111, digit_idx, digit_code);
      end
    end
    $display("enable_drop: dark on en=0, restart at slot 0 with blank phase");
  endtask

  task automatic test_boundary_collision();
    logic [15:0] ev;
    wait_frame("collision");
    capture_frame(5, 16'h1111, 30, 16'h9999);
    ev = 16'h5678;
    for (int k = 0; k < 32; k++) begin
      checks++;
      if (obs_an[k] !== exp_an(k/8, k%8, 4'hF) || obs_dc[k] !== ev[4*(k/8) +: 4] || obs_fd[k] !== (k == 31)) begin
        failures++;
        $display("FAIL collide_old k=%0d an_n=%b req=%b code=%h req=%h fd=%b req=%b",
                 k, obs_an[k], exp_an(k/8, k%8, 4'hF), obs_dc[k], ev[4*(k/8) +: 4], obs_fd[k], k == 31);
      end
    end
    checks++;
    if (dut.pend_vld_reg !== 1'b0) begin
      failures++;
      $display("FAIL collide_pend_vld pend_vld=%b required=0", dut.pend_vld_reg);
    end
    capture_frame(-1, 16'h0, -1, 16'h0);
    ev = 16'h9999;
    for (int k = 0; k < 32; k++) begin
      checks++;
      if (obs_an[k] !== exp_an(k/8, k%8, 4'hF) || obs_dc[k] !== ev[4*(k/8) +: 4] || obs_fd[k] !== (k == 31)) begin
        failures++;
        $display("FAIL collide_new k=%0d an_n=%b req=%b code=%h req=%h fd=%b req=%b",
                 k, obs_an[k], exp_an(k/8, k%8, 4'hF), obs_dc[k], ev[4*(k/8) +: 4], obs_fd[k], k == 31);
      end
    end
    $display("boundary_collision: load on boundary cycle shown next frame");
  endtask

  task automatic test_leading_zeros();
    logic [15:0] ev;
    lz_en = 1'b1;
    load = 1'b1; value = 16'h0070;
    capture_frame(-1, 16'h0, -1, 16'h0);
    capture_frame(-1, 16'h0, -1, 16'h0);
    ev = 16'h0070;
    for (int k = 0; k < 32; k++) begin
      checks++;
      if (obs_an[k] !== exp_an(k/8, k%8, 4'b0011) || obs_dc[k] !== ev[4*(k/8) +: 4] || obs_fd[k] !== (k == 31)) begin
        failures++;
        $display("FAIL lz_on k=%0d an_n=%b req=%b code=%h req=%h fd=%b req=%b",
                 k, obs_an[k], exp_an(k/8, k%8, 4'b0011), obs_dc[k], ev[4*(k/8) +: 4], obs_fd[k], k == 31);
      end
    end
    lz_en = 1'b0;
    capture_frame(-1, 16'h0, -1, 16'h0);
    for (int k = 0; k < 32; k++) begin
      checks++;
      if (obs_an[k] !== exp_an(k/8, k%8, 4'hF) || obs_dc[k] !== ev[4*(k/8) +: 4] || obs_fd[k] !== (k == 31)) begin
        failures++;
        $display("FAIL lz_off k=%0d an_n=%b req=%b code=%h req=%h fd=%b req=%b",
                 k, obs_an[k], exp_an(k/8, k%8, 4'hF), obs_dc[k], ev[4*(k/8) +: 4], obs_fd[k], k == 31);
      end
    end
    $display("leading_zeros: 0070 with lz_en=1 and lz_en=0 checked");
  endtask

  task automatic test_async_reset();
    wait_frame("areset");
    repeat (12) @(negedge clk);
    checks++;
    if (an_n !== 4'b1101 || digit_code !== 4'h7) begin
      failures++;
      $display("FAIL areset_pre an_n=%b code=%h required 1101/7", an_n, digit_code);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (an_n !== 4'hF || digit_code !== 4'h0 || frame_done !== 1'b0 || digit_idx !== 2'd0) begin
      failures++;
      $display("FAIL areset_immediate an_n=%b code=%h fd=%b idx=%0d required 1111/0/0/0",
               an_n, digit_code, frame_done, digit_idx);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    $display("async_reset: mid-scan reset clears outputs without a clock");
  endtask

  initial begin
    test_reset();
    test_scan_order();
    test_no_tear();
    test_enable_drop();
    test_boundary_collision();
    test_leading_zeros();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
